// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// dma_bus_arbiter: SCSI DMA bus tenure sequencer (BR/BG/BGACK, bounded bursts).
// Optional cycle watchdog enabled by defining DMA_TENURE_WDT_EN.   Rev 1.0
// ============================================================================
module dma_bus_arbiter #(
  parameter int MAX_BURST  = 4,
  parameter int HOLDOFF    = 2,
  parameter int WDT_CYCLES = 64
) (
  input  logic nCLK,
  input  logic RST,
  input  logic DMAENA,
  input  logic DMADIR,
  input  logic FLUSHFIFO,
  input  logic FIFOFULL,
  input  logic FIFOEMPTY,
  input  logic aBG_,
  input  logic aAS_,
  input  logic aBGACK_,
  input  logic CYC_DONE,
  output logic BR,
  output logic OWN,
  output logic CYC_REQ,
  output logic WDT_ERR
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_GWAIT = 3'd2;
  localparam logic [2:0] ST_OWN   = 3'd3;
  localparam logic [2:0] ST_REL   = 3'd4;
  localparam logic [2:0] ST_HOFF  = 3'd5;

  localparam logic [3:0] MAX_BEATS = 4'(MAX_BURST);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  logic [2:0] state;
  logic [1:0] bg_sync;
  logic [1:0] as_sync;
  logic [1:0] bgack_sync;
  logic       s_bg;
  logic       s_as;
  logic       s_bgack;
  logic [3:0] beat_cnt;
  logic [3:0] beat_cnt_nxt;
  logic [7:0] hold_cnt;
  logic       busy;
  logic       busy_nxt;
  logic       beat_done;
  logic       burst_over;
  logic       start;
  logic       more;
  logic       br_q;
  logic       own_q;
  logic       cyc_req_q;
  logic       wdt_trip;
  logic       wdt_err_flag;

  // Bus pins are asynchronous; synchronisers idle at the negated (high) level.
  always_ff @(posedge nCLK) begin
    if (RST) begin
      bg_sync    <= 2'b11;
      as_sync    <= 2'b11;
      bgack_sync <= 2'b11;
    end else begin
      bg_sync    <= {bg_sync[0], aBG_};
      as_sync    <= {as_sync[0], aAS_};
      bgack_sync <= {bgack_sync[0], aBGACK_};
    end
  end

  assign s_bg    = bg_sync[1];
  assign s_as    = as_sync[1];
  assign s_bgack = bgack_sync[1];

  assign start = DMAENA & (DMADIR ? (FIFOFULL | (FLUSHFIFO & ~FIFOEMPTY)) : FIFOEMPTY);
  assign more  = DMAENA & (DMADIR ? ~FIFOEMPTY : ~FIFOFULL);

  assign beat_done    = busy & CYC_DONE;
  assign beat_cnt_nxt = (beat_done && (beat_cnt != MAX_BEATS)) ? beat_cnt + 4'd1 : beat_cnt;
  assign busy_nxt     = busy & ~CYC_DONE & ~wdt_trip;
  assign burst_over   = (beat_cnt_nxt == MAX_BEATS) | ~more | wdt_trip;

`ifdef DMA_TENURE_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  assign wdt_trip = (state == ST_OWN) & busy & ~CYC_DONE & (wdt_cnt == WDT_LAST);

  always_ff @(posedge nCLK) begin
    if (RST) begin
      wdt_cnt      <= '0;
      wdt_err_flag <= 1'b0;
    end else begin
      if ((state == ST_OWN) && busy && !CYC_DONE) begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      end else begin
        wdt_cnt <= '0;
      end
      if (wdt_trip) begin
        wdt_err_flag <= 1'b1;
      end
    end
  end
`else
  assign wdt_trip     = 1'b0;
  assign wdt_err_flag = 1'b0;
`endif

  always_ff @(posedge nCLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      br_q      <= 1'b0;
      own_q     <= 1'b0;
      cyc_req_q <= 1'b0;
      busy      <= 1'b0;
      beat_cnt  <= 4'd0;
      hold_cnt  <= 8'd0;
    end else begin
      cyc_req_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !wdt_err_flag) begin
            state <= ST_REQ;
            br_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!start) begin
            state <= ST_IDLE;
            br_q  <= 1'b0;
          end else if (!s_bg) begin
            state <= ST_GWAIT;
          end
        end
        ST_GWAIT: begin
          if (!DMAENA) begin
            state <= ST_IDLE;
            br_q  <= 1'b0;
          end else if (s_bg) begin
            state <= ST_REQ;
          end else if (s_as && s_bgack) begin
            state    <= ST_OWN;
            own_q    <= 1'b1;
            br_q     <= 1'b0;
            beat_cnt <= 4'd0;
            busy     <= 1'b0;
          end
        end
        ST_OWN: begin
          beat_cnt <= beat_cnt_nxt;
          busy     <= busy_nxt;
          // A completing beat is judged with its own increment, so no extra request slips out.
          if (!busy_nxt && burst_over) begin
            state <= ST_REL;
            own_q <= 1'b0;
          end else if (!busy_nxt) begin
            cyc_req_q <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_REL: begin
          hold_cnt <= 8'd0;
          state    <= (HOLDOFF == 0) ? ST_IDLE : ST_HOFF;
        end
        ST_HOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          br_q  <= 1'b0;
          own_q <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BR      = br_q;
  assign OWN     = own_q;
  assign CYC_REQ = cyc_req_q;
  assign WDT_ERR = wdt_err_flag;

endmodule
`default_nettype wire
